div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Sequential controller that runs one restoring shift-subtract division step per clock on an internal accumulator/quotient datapath.
Replaces the fully unrolled combinational divider where timing closure matters, and exposes a start/busy/done handshake to the CPU's MUL/DIV execute stage.
Produces quotient and remainder, and flags divide-by-zero.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock; one clock domain, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  single-cycle pulse: results valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The counter and internal registers are cleared, and any in-flight operation is discarded.
- States:
  - IDLE: wait for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Accepting start: start is accepted in IDLE or DONE. Operands are latched on the accepting edge (cycle T). Internal Q=dividend, M=divisor, A=0 (WIDTH+1 bits), step counter=WIDTH-1.
- Divide by zero: divisor==0 at accept goes directly to DONE at T+1 with no RUN cycles. Outputs: quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN step, one per cycle:
  - A={A[WIDTH-1:0],Q[WIDTH-1]}, Q={Q[WIDTH-2:0],0}, A=A-M.
  - If A[WIDTH] (the sign of the WIDTH+1-bit result) is 1: restore A=A+M and set Q[0]=0. Otherwise Q[0]=1.
  - Counter decrements each step. When the counter is 0 at a step, the next state is DONE.
- Latency: RUN occupies T+1..T+WIDTH. In DONE at T+WIDTH+1: done=1, quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0. Total is WIDTH+1 cycles from accept to done (33 for WIDTH=32).
- busy=1 exactly during RUN cycles. done is never high in the same cycle as busy.
- start while busy=1 is ignored (no queueing); operand changes during RUN have no effect.
- start asserted in the DONE cycle is accepted (back-to-back). done still pulses for the finishing operation.
- Outputs quotient, remainder and div_by_zero update only on entry to DONE and are otherwise stable.
- No arithmetic overflow is possible in unsigned mode. The remainder is always < divisor when divisor≠0.

Optional Feature:
Macro DIV_SIGNED_EN.
- Defined:
  - Adds input signed_op (1 bit), sampled with start.
  - When signed_op=1, operands are two's complement. Magnitudes are divided; the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign (truncating division). Sign fix-up is registered on entry to DONE, so latency is unchanged.
  - Most-negative / -1 returns quotient=most-negative, remainder=0.
  - Divide by zero returns quotient=all ones, remainder=dividend, div_by_zero=1.
- Undefined: the signed_op port is absent and behaviour is unsigned only.

Decomposition:
- Package div_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant, counter width as $clog2(WIDTH).
- One sub-module div_step: a purely combinational single restoring iteration. Inputs: A, Q, M. Outputs: next A, next Q.
- The controller owns the FSM, the counter, the operand registers and result registers.

Test Plan:
- dividend=100, divisor=7, start one cycle -> busy 32 cycles; done pulse 33 cycles after accept with quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- divisor=0, dividend=0x1234 -> done at T+1, busy never high, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Start 100/7, then pulse start with 50/5 at cycle T+10 -> second request ignored; result 14 r 2. Start 50/5 in the DONE cycle -> accepted; next done gives 10 r 0.
- Start 1000/3, assert reset at T+15 -> next cycle busy=0, done=0, all outputs 0. No done pulse appears afterwards.
- With DIV_SIGNED_EN, signed_op=1:
  - -7/2 -> quotient=-3, remainder=-1.
  - 0x80000000/-1 -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// signed_op exists only when DIV_SIGNED_EN is defined.
interface div_seq_ctrl_if #(parameter int WIDTH = div_pkg::DEFAULT_WIDTH);

`ifdef DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
`ifdef DIV_SIGNED_EN
        output signed_op,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef DIV_SIGNED_EN
        input  signed_op,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One combinational restoring shift-subtract division iteration.
module div_step #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    // A stays below M after every restore, so only the trial result needs the extra sign bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {a_i, q_i[WIDTH-1]};
        trial   = shifted - {1'b0, m_i};
        if (trial[WIDTH]) begin
            a_o = shifted[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            a_o = trial[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential divider controller: one restoring step per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to add two's-complement truncating division via signed_op.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    div_seq_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_a, step_q;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] fin_quot, fin_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic quo_neg_q, quo_neg_d;
    logic rem_neg_q, rem_neg_d;
    logic dvd_neg, dvs_neg;

    // Divide magnitudes, then fix signs on the way into the result registers.
    assign dvd_neg  = bus.signed_op & bus.dividend[WIDTH-1];
    assign dvs_neg  = bus.signed_op & bus.divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
    assign fin_quot = quo_neg_q ? -step_q : step_q;
    assign fin_rem  = rem_neg_q ? -step_a : step_a;
`else
    assign dvd_mag  = bus.dividend;
    assign dvs_mag  = bus.divisor;
    assign fin_quot = step_q;
    assign fin_rem  = step_a;
`endif

    // NOTE: every _d gets its hold value first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = fin_quot;
                    rem_d   = fin_rem;
                    dbz_d   = 1'b0;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d   = '0;
                    q_d   = dvd_mag;
                    m_d   = dvs_mag;
                    cnt_d = CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                    quo_neg_d = dvd_neg ^ dvs_neg;
                    rem_neg_d = dvd_neg;
`endif
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: arithmetic reference model plus directed vectors.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: quotient/remainder from plain arithmetic, timing as a cycle countdown.
    function automatic void model_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                      input bit sgn, output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (dvs == '0) begin
            q = '1;
            r = dvd;
        end else if (sgn) begin
            sa = longint'($signed(dvd));
            sb = longint'($signed(dvs));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = dvd / dvs;
            r = dvd % dvs;
        end
    endfunction

    bit             model_valid = 1'b0;
    int             m_run_left;
    bit             m_done, m_z;
    logic [W-1:0]   m_q, m_r, p_q, p_r;

    always @(posedge clk) begin
        bit sgn;
        logic [W-1:0] nq, nr;
`ifdef DIV_SIGNED_EN
        sgn = bus.signed_op;
`else
        sgn = 1'b0;
`endif
        if (reset) begin
            model_valid = 1'b1;
            m_run_left  = 0;
            m_done      = 1'b0;
            m_z         = 1'b0;
            m_q         = '0;
            m_r         = '0;
        end else if (model_valid) begin
            m_done = 1'b0;
            if (m_run_left > 0) begin
                m_run_left--;
                if (m_run_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = 1'b0;
                end
            end else if (bus.start) begin
                model_div(bus.dividend, bus.divisor, sgn, nq, nr);
                if (bus.divisor == '0) begin
                    m_done = 1'b1;
                    m_q    = nq;
                    m_r    = nr;
                    m_z    = 1'b1;
                end else begin
                    m_run_left = W;
                    p_q        = nq;
                    p_r        = nr;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", W'(bus.busy), W'(m_run_left > 0));
            check("done", W'(bus.done), W'(m_done));
            check("quotient", bus.quotient, m_q);
            check("remainder", bus.remainder, m_r);
            check("div_by_zero", W'(bus.div_by_zero), W'(m_z));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit sgn);
`ifdef DIV_SIGNED_EN
        bus.signed_op = sgn;
`else
        if (sgn) $display("signed request issued without DIV_SIGNED_EN");
`endif
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        cycle();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 100) begin
            cycle();
            lat++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input bit sgn, input int exp_lat, input logic [W-1:0] exp_q,
                          input logic [W-1:0] exp_r, input bit exp_z);
        int lat;
        start_op(dvd, dvs, sgn);
        wait_done(lat);
        check({name, "_latency"}, W'(lat), W'(exp_lat));
        check({name, "_q"}, bus.quotient, exp_q);
        check({name, "_r"}, bus.remainder, exp_r);
        check({name, "_z"}, W'(bus.div_by_zero), W'(exp_z));
        cycle();
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        cycle();
        cycle();
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_q", bus.quotient, '0);
        check("reset_r", bus.remainder, '0);
        reset = 1'b0;
        cycle();

        run_op("d100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        run_op("max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("d5_9", 32'd5, 32'd9, 1'b0, 33, 32'd0, 32'd5, 1'b0);
        run_op("d7_7", 32'd7, 32'd7, 1'b0, 33, 32'd1, 32'd0, 1'b0);
        run_op("d0_5", 32'd0, 32'd5, 1'b0, 33, 32'd0, 32'd0, 1'b0);
        run_op("big", 32'd305419896, 32'd1000, 1'b0, 33, 32'd305419, 32'd896, 1'b0);

        // Divide by zero finishes on the very next cycle without ever raising busy.
        start_op(32'h1234, 32'd0, 1'b0);
        check("dbz_busy", W'(bus.busy), '0);
        wait_done(lat);
        check("dbz_latency", W'(lat), W'(1));
        check("dbz_q", bus.quotient, 32'hFFFF_FFFF);
        check("dbz_r", bus.remainder, 32'h1234);
        check("dbz_z", W'(bus.div_by_zero), W'(1));
        cycle();

        // Start during RUN is dropped; start in the DONE cycle is taken.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) cycle();
        start_op(32'd50, 32'd5, 1'b0);
        wait_done(lat);
        check("ignored_q", bus.quotient, 32'd14);
        check("ignored_r", bus.remainder, 32'd2);
        start_op(32'd50, 32'd5, 1'b0);
        wait_done(lat);
        check("b2b_latency", W'(lat), W'(33));
        check("b2b_q", bus.quotient, 32'd10);
        check("b2b_r", bus.remainder, 32'd0);
        cycle();

        // Mid-operation reset discards the job and clears results.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (14) cycle();
        reset = 1'b1;
        cycle();
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_q", bus.quotient, '0);
        check("rst_r", bus.remainder, '0);
        check("rst_z", W'(bus.div_by_zero), '0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            check("rst_no_done", W'(bus.done), '0);
        end

`ifdef DIV_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);
        run_op("s_dbz", 32'hFFFF_FFF9, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`endif

        repeat (3) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
